// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution stage.
// Computes the JAL/JALR/B-type target, evaluates the branch condition,
// compares against the fetch prediction and holds one result behind a
// valid/ready handshake. Keeps saturating branch/mispredict counters.
// Optional feature macro: BRANCH_MISALIGN_TRAP_EN (taken targets with
// bit 1 set are flagged misaligned instead of redirecting).
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic                 i_jump,
  input  logic                 i_jalr,
  input  logic [WIDTH-1:0]     i_pc,
  input  logic [WIDTH-1:0]     i_rs1,
  input  logic [WIDTH-1:0]     i_rs2,
  input  logic [WIDTH-1:0]     i_immediate,
  input  logic                 i_pred_taken,
  input  logic [WIDTH-1:0]     i_pred_target,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_taken,
  output logic                 o_mispredict,
  output logic                 o_misaligned,
  output logic [WIDTH-1:0]     o_target,
  output logic [WIDTH-1:0]     o_redirect_pc,
  output logic [WIDTH-1:0]     o_link,
  output logic [CNT_WIDTH-1:0] o_branch_count,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);

  // Result and statistics registers
  logic                 valid_q, valid_d;
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic                 misaligned_q, misaligned_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [WIDTH-1:0]     redirect_q, redirect_d;
  logic [WIDTH-1:0]     link_q, link_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // Combinational resolution of the incoming instruction
  logic             cond_c;
  logic             taken_c;
  logic             mispredict_c;
  logic             misaligned_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] link_c;
  logic [WIDTH-1:0] redirect_c;

  logic accept;
  logic transfer;

  // The slot frees up when empty or when the consumer drains it this cycle
  assign o_ready  = !valid_q || i_ready;
  assign accept   = i_valid && o_ready && !i_flush;
  assign transfer = valid_q && i_ready;

  // Target/link arithmetic, condition evaluation and prediction check
  always_comb begin
    sum_c    = (i_jalr ? i_rs1 : i_pc) + i_immediate;
    // JALR drops bit 0 of the computed address
    target_c = {sum_c[WIDTH-1:1], (i_jalr ? 1'b0 : sum_c[0])};
    link_c   = i_pc + WIDTH'(4);

    cond_c = 1'b0;
    case (i_op)
      3'b000:  cond_c = (i_rs1 == i_rs2);
      3'b001:  cond_c = (i_rs1 != i_rs2);
      3'b100:  cond_c = ($signed(i_rs1) <  $signed(i_rs2));
      3'b101:  cond_c = ($signed(i_rs1) >= $signed(i_rs2));
      3'b110:  cond_c = (i_rs1 <  i_rs2);
      3'b111:  cond_c = (i_rs1 >= i_rs2);
      default: cond_c = 1'b0;  // 010/011 are not branch conditions
    endcase

    taken_c = i_jump || cond_c;

`ifdef BRANCH_MISALIGN_TRAP_EN
    // A misaligned taken target traps: no redirect to it, no mispredict
    misaligned_c = taken_c && target_c[1];
    if (misaligned_c) begin
      mispredict_c = 1'b0;
      redirect_c   = link_c;
    end else begin
      mispredict_c = (taken_c != i_pred_taken) ||
                     (taken_c && (i_pred_target != target_c));
      redirect_c   = taken_c ? target_c : link_c;
    end
`else
    // Halfword-aligned targets are legal when compressed code is present
    misaligned_c = 1'b0;
    mispredict_c = (taken_c != i_pred_taken) ||
                   (taken_c && (i_pred_target != target_c));
    redirect_c   = taken_c ? target_c : link_c;
`endif
  end

  // Next-state: result load on accept, valid tracking, saturating counters
  always_comb begin
    valid_d       = valid_q;
    taken_d       = taken_q;
    mispredict_d  = mispredict_q;
    misaligned_d  = misaligned_q;
    target_d      = target_q;
    redirect_d    = redirect_q;
    link_d        = link_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      taken_d      = taken_c;
      mispredict_d = mispredict_c;
      misaligned_d = misaligned_c;
      target_d     = target_c;
      redirect_d   = redirect_c;
      link_d       = link_c;
    end

    // A transfer completes even in a flush cycle, so it is always counted
    if (transfer) begin
      if (branch_cnt_q != {CNT_WIDTH{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict_q && (mispred_cnt_q != {CNT_WIDTH{1'b1}})) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State register with synchronous reset overriding flush and input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      misaligned_q  <= 1'b0;
      target_q      <= '0;
      redirect_q    <= '0;
      link_q        <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      misaligned_q  <= misaligned_d;
      target_q      <= target_d;
      redirect_q    <= redirect_d;
      link_q        <= link_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_valid            = valid_q;
  assign o_taken            = taken_q;
  assign o_mispredict       = mispredict_q;
  assign o_misaligned       = misaligned_q;
  assign o_target           = target_q;
  assign o_redirect_pc      = redirect_q;
  assign o_link             = link_q;
  assign o_branch_count     = branch_cnt_q;
  assign o_mispredict_count = mispred_cnt_q;

endmodule
